// File: rtl/image_boot_loader.sv
// Boot loader front end: assembles 384 UART bytes into one 3072-bit row of 256
// 12-bit pixels and writes each finished row to the frame store boot port.
module image_boot_loader #(
    parameter int NUM_ROWS = 512
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          bootloading,
    output logic          we_boot,
    output logic [8:0]    waddr_boot,
    output logic [3071:0] wdata_boot,
    output logic          done,
    output logic          overrun
);

    // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte is
    // consumed only in LOAD, and bytes arriving in any other state are lost.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [8:0] LAST_BYTE = 9'd383;
    localparam logic [8:0] LAST_ROW  = 9'(NUM_ROWS - 1);

    state_t     state;
    state_t     next_state;
    logic [8:0] byte_cnt;
    logic [8:0] row_cnt;

    assign waddr_boot = row_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = LOAD;
            LOAD:       if (rx_valid && (byte_cnt == LAST_BYTE)) next_state = WRITE;
            WRITE:      next_state = (row_cnt == LAST_ROW) ? DONE : LOAD;
            default:    next_state = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track the FSM
    // cycle-exactly without any combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bootloading <= 1'b0;
            we_boot     <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            byte_cnt    <= '0;
            row_cnt     <= '0;
            wdata_boot  <= '0;
        end else begin
            bootloading <= (next_state == LOAD) || (next_state == WRITE);
            we_boot     <= (next_state == WRITE);
            done        <= (next_state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_cnt <= '0;
                        row_cnt  <= '0;
                        overrun  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        // Left shift puts the first byte at the top: pixel k lands at [3071-12k -: 12].
                        wdata_boot <= {wdata_boot[3063:0], rx_data};
                        byte_cnt   <= (byte_cnt == LAST_BYTE) ? 9'd0 : byte_cnt + 9'd1;
                    end
                end
                WRITE: begin
                    if (rx_valid) overrun <= 1'b1;
                    if (row_cnt != LAST_ROW) row_cnt <= row_cnt + 9'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_boot_loader.sv
// Bench for image_boot_loader: a 5-row instance for the main scenarios and a
// 1-row instance for the single-row case, both fed from one shared byte stream.
module tb_image_boot_loader;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;

    logic          a_boot, a_we, a_done, a_ovr;
    logic [8:0]    a_waddr;
    logic [3071:0] a_wdata;
    logic          b_boot, b_we, b_done, b_ovr;
    logic [8:0]    b_waddr;
    logic [3071:0] b_wdata;

    int checks   = 0;
    int failures = 0;
    int a_we_cnt = 0;
    int b_we_cnt = 0;

    logic [7:0] row_bytes [384];

    image_boot_loader #(.NUM_ROWS(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .bootloading(a_boot), .we_boot(a_we), .waddr_boot(a_waddr), .wdata_boot(a_wdata),
        .done(a_done), .overrun(a_ovr)
    );

    image_boot_loader #(.NUM_ROWS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .bootloading(b_boot), .we_boot(b_we), .waddr_boot(b_waddr), .wdata_boot(b_wdata),
        .done(b_done), .overrun(b_ovr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (a_we === 1'b1) a_we_cnt++;
        if (b_we === 1'b1) b_we_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic apply_reset();
        #5 rst_n = 1'b0;
        rx_valid = 1'b0;
        start = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 384; i++) row_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom_range(0, 255));
            step();
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) step();
        end
    endtask

    // Sends row_bytes into the stream; returns in the cycle right after the
    // last byte was taken, which is where the row write must be visible.
    task automatic send_row(input int row, input int start_at);
        int early;
        int bad;
        int m;
        logic [11:0] exp_pix;
        early = 0;
        for (int i = 0; i < 384; i++) begin
            rx_valid = 1'b1;
            rx_data  = row_bytes[i];
            if (i == start_at) start = 1'b1;
            step();
            rx_valid = 1'b0;
            start    = 1'b0;
            if (i < 383) begin
                if (a_we !== 1'b0 || a_boot !== 1'b1) early++;
                repeat ($urandom_range(1, 3)) step();
            end
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL early_write row=%0d got=%0d bad cycles exp=0", row, early);
        end
        checks++;
        if (a_we !== 1'b1 || a_waddr !== 9'(row) || a_boot !== 1'b1) begin
            failures++;
            $display("FAIL row_write row=%0d got we=%b addr=%0d boot=%b exp we=1 addr=%0d boot=1",
                     row, a_we, a_waddr, a_boot, row);
        end
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            m = k / 2;
            if (k % 2 == 0) exp_pix = {row_bytes[3*m], row_bytes[3*m+1][7:4]};
            else            exp_pix = {row_bytes[3*m+1][3:0], row_bytes[3*m+2]};
            if (a_wdata[3071-12*k -: 12] !== exp_pix) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL row_pixels row=%0d got=%0d wrong pixels exp=0", row, bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) step();
        checks++;
        if ({a_boot, a_we, a_done, a_ovr, b_boot, b_we, b_done, b_ovr} !== 8'h00 ||
            a_waddr !== 9'd0 || a_wdata !== '0 || b_waddr !== 9'd0 || b_wdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs got a=%b%b%b%b addr=%0d b=%b%b%b%b exp all zero",
                     a_boot, a_we, a_done, a_ovr, a_waddr, b_boot, b_we, b_done, b_ovr);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ignored_idle();
        int w0;
        w0 = a_we_cnt;
        send_bytes(10);
        checks++;
        if (a_boot !== 1'b0 || a_done !== 1'b0 || a_wdata !== '0 || a_we_cnt != w0) begin
            failures++;
            $display("FAIL idle_bytes got boot=%b done=%b writes=%0d exp boot=0 done=0 writes=0 wdata=0",
                     a_boot, a_done, a_we_cnt - w0);
        end
    endtask

    task automatic test_single_row();
        int wb;
        logic [11:0] p0, p1;
        wb = b_we_cnt;
        do_start();
        for (int m = 0; m < 128; m++) begin
            p0 = 12'(2 * m);
            p1 = 12'(2 * m + 1);
            row_bytes[3*m]   = p0[11:4];
            row_bytes[3*m+1] = {p0[3:0], p1[11:8]};
            row_bytes[3*m+2] = p1[7:0];
        end
        send_row(0, -1);
        checks++;
        if (b_we !== 1'b1 || b_waddr !== 9'd0 || b_boot !== 1'b1) begin
            failures++;
            $display("FAIL single_write got we=%b addr=%0d boot=%b exp we=1 addr=0 boot=1", b_we, b_waddr, b_boot);
        end
        checks++;
        if (b_wdata[3071:3060] !== 12'h000 || b_wdata[11:0] !== 12'h0FF) begin
            failures++;
            $display("FAIL single_pixels got first=%h last=%h exp first=000 last=0ff",
                     b_wdata[3071:3060], b_wdata[11:0]);
        end
        step();
        checks++;
        if (b_done !== 1'b1 || b_boot !== 1'b0 || b_we !== 1'b0 || b_we_cnt - wb != 1) begin
            failures++;
            $display("FAIL single_done got done=%b boot=%b we=%b writes=%0d exp done=1 boot=0 we=0 writes=1",
                     b_done, b_boot, b_we, b_we_cnt - wb);
        end
        apply_reset();
    endtask

    task automatic load_rows(input int first, input int mid_start);
        for (int r = first; r < 5; r++) begin
            fill_random();
            send_row(r, (r == mid_start) ? 150 : -1);
            step();
            checks++;
            if (r < 4) begin
                if (a_we !== 1'b0 || a_waddr !== 9'(r + 1) || a_boot !== 1'b1 || a_done !== 1'b0) begin
                    failures++;
                    $display("FAIL next_row got we=%b addr=%0d boot=%b done=%b exp we=0 addr=%0d boot=1 done=0",
                             a_we, a_waddr, a_boot, a_done, r + 1);
                end
            end else begin
                if (a_we !== 1'b0 || a_boot !== 1'b0 || a_done !== 1'b1) begin
                    failures++;
                    $display("FAIL load_done got we=%b boot=%b done=%b exp we=0 boot=0 done=1",
                             a_we, a_boot, a_done);
                end
            end
        end
    endtask

    task automatic test_full_load();
        int w0;
        w0 = a_we_cnt;
        do_start();
        load_rows(0, 2);
        checks++;
        if (a_we_cnt - w0 != 5 || a_ovr !== 1'b0) begin
            failures++;
            $display("FAIL full_load got writes=%0d overrun=%b exp writes=5 overrun=0", a_we_cnt - w0, a_ovr);
        end
    endtask

    task automatic test_ignored_done();
        int w0;
        w0 = a_we_cnt;
        send_bytes(8);
        checks++;
        if (a_done !== 1'b1 || a_boot !== 1'b0 || a_we_cnt != w0) begin
            failures++;
            $display("FAIL done_bytes got done=%b boot=%b writes=%0d exp done=1 boot=0 writes=0",
                     a_done, a_boot, a_we_cnt - w0);
        end
    endtask

    task automatic test_restart();
        do_start();
        checks++;
        if (a_done !== 1'b0 || a_boot !== 1'b1 || a_waddr !== 9'd0) begin
            failures++;
            $display("FAIL restart got done=%b boot=%b addr=%0d exp done=0 boot=1 addr=0", a_done, a_boot, a_waddr);
        end
        fill_random();
        send_row(0, -1);
        step();
        apply_reset();
    endtask

    task automatic test_overrun();
        do_start();
        fill_random();
        send_row(0, -1);
        rx_valid = 1'b1;
        rx_data  = 8'($urandom_range(0, 255));
        step();
        rx_valid = 1'b0;
        checks++;
        if (a_ovr !== 1'b1 || a_we !== 1'b0 || a_waddr !== 9'd1) begin
            failures++;
            $display("FAIL overrun_set got ovr=%b we=%b addr=%0d exp ovr=1 we=0 addr=1", a_ovr, a_we, a_waddr);
        end
        load_rows(1, -1);
        checks++;
        if (a_ovr !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold got=%b exp=1", a_ovr);
        end
        do_start();
        checks++;
        if (a_ovr !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got=%b exp=0", a_ovr);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_row();
        int w0;
        do_start();
        for (int r = 0; r < 3; r++) begin
            fill_random();
            send_row(r, -1);
            step();
        end
        send_bytes(200);
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_boot, a_we, a_done, a_ovr} !== 4'h0 || a_waddr !== 9'd0 || a_wdata !== '0) begin
            failures++;
            $display("FAIL async_reset got boot=%b we=%b done=%b ovr=%b addr=%0d exp all zero",
                     a_boot, a_we, a_done, a_ovr, a_waddr);
        end
        step();
        rst_n = 1'b1;
        step();
        w0 = a_we_cnt;
        do_start();
        fill_random();
        send_row(0, -1);
        step();
        checks++;
        if (a_we_cnt - w0 != 1) begin
            failures++;
            $display("FAIL reset_restart got writes=%0d exp=1", a_we_cnt - w0);
        end
    endtask

    initial begin
        test_reset();
        test_ignored_idle();
        test_single_row();
        test_full_load();
        test_ignored_done();
        test_restart();
        test_overrun();
        test_reset_mid_row();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
